// File: rtl/serial_word_subtractor.sv
// Byte-serial word subtractor sequencer: drives an external combinational byte
// subtractor one slice per clock (LSB first) and assembles the result and flags.
module serial_word_subtractor #(
  parameter int WORD_WIDTH = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_a,
  input  logic [WORD_WIDTH-1:0] word_b,
  input  logic                  word_borrow_in,
  output logic [DATA_WIDTH-1:0] byte_a,
  output logic [DATA_WIDTH-1:0] byte_b,
  output logic                  byte_borrow_in,
  output logic                  byte_start,
  input  logic [DATA_WIDTH-1:0] byte_diff,
  input  logic                  byte_borrow_out,
  output logic [WORD_WIDTH-1:0] word_diff,
  output logic                  word_borrow_out,
  output logic                  word_zero,
  output logic                  word_overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int NUM_BYTES = WORD_WIDTH / DATA_WIDTH;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state;
  logic [IDX_W-1:0]      idx;
  logic                  borrow_reg;
  logic [WORD_WIDTH-1:0] a_reg;
  logic [WORD_WIDTH-1:0] b_reg;

  logic last_slice;
  logic lower_zero;

  assign last_slice = (state == ST_RUN) && (idx == IDX_W'(NUM_BYTES - 1));
  // word_diff is cleared on start, so the lower slices hold exactly the bytes captured so far.
  assign lower_zero = (word_diff[WORD_WIDTH-DATA_WIDTH-1:0] == '0);

  // Slice presentation to the byte subtractor; the borrow comes only from borrow_reg.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    byte_a         = '0;
    byte_b         = '0;
    byte_borrow_in = 1'b0;
    byte_start     = 1'b0;
    if (state == ST_RUN) begin
      byte_a         = a_reg[idx*DATA_WIDTH +: DATA_WIDTH];
      byte_b         = b_reg[idx*DATA_WIDTH +: DATA_WIDTH];
      byte_borrow_in = borrow_reg;
      byte_start     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state           <= ST_IDLE;
      idx             <= '0;
      borrow_reg      <= 1'b0;
      a_reg           <= '0;
      b_reg           <= '0;
      word_diff       <= '0;
      word_borrow_out <= 1'b0;
      word_zero       <= 1'b0;
      word_overflow   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          a_reg           <= word_a;
          b_reg           <= word_b;
          borrow_reg      <= word_borrow_in;
          idx             <= '0;
          word_diff       <= '0;
          word_borrow_out <= 1'b0;
          word_zero       <= 1'b0;
          word_overflow   <= 1'b0;
          busy            <= 1'b1;
          state           <= ST_RUN;
        end
      end else begin
        word_diff[idx*DATA_WIDTH +: DATA_WIDTH] <= byte_diff;
        borrow_reg <= byte_borrow_out;
        idx        <= idx + 1'b1;
        if (last_slice) begin
          word_borrow_out <= byte_borrow_out;
          word_zero       <= lower_zero && (byte_diff == '0);
          // Signed overflow: operands differ in sign and result sign differs from minuend.
          word_overflow   <= (a_reg[WORD_WIDTH-1] != b_reg[WORD_WIDTH-1]) &&
                             (byte_diff[DATA_WIDTH-1] != a_reg[WORD_WIDTH-1]);
          done            <= 1'b1;
          busy            <= 1'b0;
          idx             <= '0;
          state           <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_word_subtractor.sv
// Directed self-checking bench for serial_word_subtractor with a behavioural
// byte subtractor attached to the slice interface.
module tb_serial_word_subtractor;

  localparam int WW = 32;
  localparam int DW = 8;
  localparam int NB = WW / DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [WW-1:0] word_a = '0;
  logic [WW-1:0] word_b = '0;
  logic          word_borrow_in = 1'b0;
  logic [DW-1:0] byte_a, byte_b, byte_diff;
  logic          byte_borrow_in, byte_start, byte_borrow_out;
  logic [WW-1:0] word_diff;
  logic          word_borrow_out, word_zero, word_overflow, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_word_subtractor #(.WORD_WIDTH(WW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .word_a(word_a), .word_b(word_b), .word_borrow_in(word_borrow_in),
    .byte_a(byte_a), .byte_b(byte_b), .byte_borrow_in(byte_borrow_in),
    .byte_start(byte_start), .byte_diff(byte_diff), .byte_borrow_out(byte_borrow_out),
    .word_diff(word_diff), .word_borrow_out(word_borrow_out), .word_zero(word_zero),
    .word_overflow(word_overflow), .busy(busy), .done(done)
  );

  // Attached 8-bit byte subtractor: 9-bit difference, bit 8 is the borrow.
  logic [DW:0] slice_full;
  always_comb begin
    slice_full      = {1'b0, byte_a} - {1'b0, byte_b} - {{DW{1'b0}}, byte_borrow_in};
    byte_diff       = slice_full[DW-1:0];
    byte_borrow_out = slice_full[DW];
  end

  // Starts one operation, returns result and latency (-1 on timeout) in negedges after the start edge.
  task automatic run_op(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic bin,
                        output int lat, output logic [WW-1:0] diff, output logic bo,
                        output logic z, output logic ov, output logic [WW-1:0] seq,
                        output logic pulse_ok);
    @(negedge clk);
    word_a = a; word_b = b; word_borrow_in = bin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; seq = '0; pulse_ok = 1'b0;
    diff = '0; bo = 1'b0; z = 1'b0; ov = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n < NB) seq[n*DW +: DW] = byte_a;
      if (done) begin
        lat = n; diff = word_diff; bo = word_borrow_out; z = word_zero; ov = word_overflow;
        break;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      pulse_ok = !done && (word_diff == diff);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", busy, done); end
    total++; if (word_diff !== '0) begin bad++;
      $display("FAIL reset_diff: got %h want 00000000", word_diff); end
    total++; if ({word_borrow_out, word_zero, word_overflow} !== 3'b000) begin bad++;
      $display("FAIL reset_flags: got %b want 000", {word_borrow_out, word_zero, word_overflow}); end
    total++; if ({byte_start, byte_borrow_in, byte_a, byte_b} !== '0) begin bad++;
      $display("FAIL reset_slice_if: got start=%b bin=%b a=%h b=%h want all 0",
               byte_start, byte_borrow_in, byte_a, byte_b); end
    reset_n = 1'b1;
  endtask

  task automatic check_op(input string name, input logic [WW-1:0] a, input logic [WW-1:0] b,
                          input logic bin, input logic [WW-1:0] e_diff, input logic e_bo,
                          input logic e_z, input logic e_ov);
    int lat; logic [WW-1:0] diff, seq; logic bo, z, ov, pok;
    run_op(a, b, bin, lat, diff, bo, z, ov, seq, pok);
    total++; if (lat !== NB) begin bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, NB); end
    total++; if (diff !== e_diff) begin bad++;
      $display("FAIL %s_diff: got %h want %h", name, diff, e_diff); end
    total++; if ({bo, z, ov} !== {e_bo, e_z, e_ov}) begin bad++;
      $display("FAIL %s_flags: got bo/z/ov=%b want %b", name, {bo, z, ov}, {e_bo, e_z, e_ov}); end
    total++; if (seq !== a) begin bad++;
      $display("FAIL %s_byte_a_seq: got %h want %h", name, seq, a); end
    total++; if (pok !== 1'b1) begin bad++;
      $display("FAIL %s_single_pulse_hold: got %b want 1", name, pok); end
  endtask

  task automatic test_normal();
    check_op("normal", 32'h12345678, 32'h01020304, 1'b0, 32'h11325374, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_borrow();
    check_op("borrow_a", 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0);
    check_op("borrow_b", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    check_op("ovf", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    check_op("bin", 32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_zero();
    check_op("zero", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start();
    int pulses = 0; int first = -1; logic [WW-1:0] diff = '0;
    @(negedge clk);
    word_a = 32'h12345678; word_b = 32'h01020304; word_borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      start = (n == 1);
      if (n == 1) begin word_a = 32'hFFFFFFFF; word_b = 32'h0; word_borrow_in = 1'b1; end
      if (done) begin
        pulses++;
        if (first < 0) begin first = n; diff = word_diff; end
      end
    end
    start = 1'b0;
    total++; if (pulses !== 1 || first !== NB) begin bad++;
      $display("FAIL ignore_pulses: got %0d pulses first at %0d want 1 at %0d", pulses, first, NB); end
    total++; if (diff !== 32'h11325374) begin bad++;
      $display("FAIL ignore_diff: got %h want 11325374", diff); end
  endtask

  task automatic test_back_to_back();
    int lat2 = -1; logic [WW-1:0] d1 = '0;
    @(negedge clk);
    word_a = 32'h00000100; word_b = 32'h00000001; word_borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        d1 = word_diff;
        word_a = 32'h80000000; word_b = 32'h00000001;
        break;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin lat2 = n; break; end
    end
    total++; if (d1 !== 32'h000000FF) begin bad++;
      $display("FAIL b2b_first_diff: got %h want 000000FF", d1); end
    total++; if (lat2 !== NB) begin bad++;
      $display("FAIL b2b_second_latency: got %0d want %0d", lat2, NB); end
    total++; if (word_diff !== 32'h7FFFFFFF || word_overflow !== 1'b1) begin bad++;
      $display("FAIL b2b_second_result: got %h ovf=%b want 7FFFFFFF ovf=1", word_diff, word_overflow); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk);
    word_a = 32'h12345678; word_b = 32'h01020304; word_borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || word_diff !== '0) begin bad++;
      $display("FAIL midreset_state: got busy=%b done=%b diff=%h want 0 0 0", busy, done, word_diff); end
    total++; if ({word_borrow_out, word_zero, word_overflow, byte_start} !== 4'b0) begin bad++;
      $display("FAIL midreset_flags: got %b want 0000",
               {word_borrow_out, word_zero, word_overflow, byte_start}); end
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    total++; if (pulses !== 0) begin bad++;
      $display("FAIL midreset_no_done: got %0d pulses want 0", pulses); end
    check_op("after_reset", 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_borrow();
    test_overflow();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
